// File: rtl/rx_ctrl.sv
// rx_ctrl: UART receive controller; edge-captures receiver bytes into a show-ahead FIFO with overrun and idle timeout.
module rx_ctrl #(
  parameter int DEPTH       = 8,
  parameter int AW          = 3,
  parameter int IDLE_CYCLES = 640
) (
  input  logic          clk16,
  input  logic          rst_n,
  input  logic          rx_enable,
  input  logic          fifo_flush,
  input  logic          receive_flag,
  input  logic [7:0]    para_data_out,
  output logic [7:0]    out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW:0]   fifo_count,
  output logic          overrun,
  input  logic          overrun_clr,
  output logic          rx_timeout
);
  typedef enum logic [1:0] {DISABLED, ACTIVE, FLUSH} state_t;
  state_t      state_q, state_d;
  logic        flag_q;
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [7:0]  mem_q [DEPTH];
  logic        overrun_q, overrun_d, rx_timeout_q, rx_timeout_d;
  logic [9:0]  idle_q, idle_d;
  logic        capture, full, rd_en, wr_en;

  assign fifo_count = wr_ptr_q - rd_ptr_q;
  assign out_valid  = fifo_count != '0;
  assign out_data   = mem_q[rd_ptr_q[AW-1:0]];
  assign overrun    = overrun_q;
  assign rx_timeout = rx_timeout_q;

  // A flush discards any capture or read in the same cycle.
  always_comb begin
    full         = fifo_count == (AW+1)'(DEPTH);
    capture      = receive_flag & ~flag_q & (state_q == ACTIVE) & ~fifo_flush;
    rd_en        = out_valid & out_ready & ~fifo_flush;
    wr_en        = capture & (~full | rd_en);
    state_d      = fifo_flush ? FLUSH : rx_enable ? ACTIVE : DISABLED;
    wr_ptr_d     = fifo_flush ? '0 : wr_ptr_q + (AW+1)'(wr_en);
    rd_ptr_d     = fifo_flush ? '0 : rd_ptr_q + (AW+1)'(rd_en);
    overrun_d    = (capture & full & ~rd_en) | (overrun_q & ~overrun_clr);
    idle_d       = (capture | rd_en | fifo_flush | ~out_valid) ? '0 :
                   (idle_q == 10'(IDLE_CYCLES)) ? idle_q : idle_q + 10'd1;
    rx_timeout_d = idle_d == 10'(IDLE_CYCLES);
  end

  always_ff @(posedge clk16 or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= DISABLED;
      flag_q       <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      overrun_q    <= 1'b0;
      idle_q       <= '0;
      rx_timeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      flag_q       <= receive_flag;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      overrun_q    <= overrun_d;
      idle_q       <= idle_d;
      rx_timeout_q <= rx_timeout_d;
    end
  end

  always_ff @(posedge clk16) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= para_data_out;
  end
endmodule
